// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared bitwise logic unit arbiter.
// slave: the arbiter side. master: the requesters plus the response consumer.
interface logic_unit_arbiter_if #(parameter int WIDTH = 16);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a shared XOR/AND/OR/XNOR unit with one registered response slot.
// Define LU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_unit_arbiter_if.slave bus,
  output logic [7:0]          grant_cnt0,
  output logic [7:0]          grant_cnt1
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_zero_r;
  logic             open_s;
  logic             winner_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             hs_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] result_s;

  function automatic logic [WIDTH-1:0] lu_compute(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a ^ b;
      2'b01:   r = a & b;
      2'b10:   r = a | b;
      2'b11:   r = ~(a ^ b);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

`ifdef LU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is valid
  always_comb begin
    winner_s = 1'b0;
    if (bus.req0_valid) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end
`else
  logic last_r;

  // Round-robin: on contention the requester not granted last time wins
  always_comb begin
    winner_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner_s = ~last_r;
    end else if (bus.req0_valid) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end

  // Remember the last granted requester; starts at 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (hs_s) begin
      last_r <= winner_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  // Accept window, grants and winner operand selection; ready never depends on operands
  always_comb begin
    open_s = 1'b0;
    if (state_r == IDLE) begin
      open_s = 1'b1;
    end else if (bus.rsp_ready) begin
      open_s = 1'b1;
    end else begin
      open_s = 1'b0;
    end
    grant0_s = open_s & bus.req0_valid & (winner_s == 1'b0);
    grant1_s = open_s & bus.req1_valid & (winner_s == 1'b1);
    hs_s     = grant0_s | grant1_s;
    if (winner_s) begin
      sel_op_s = bus.req1_op;
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
    end else begin
      sel_op_s = bus.req0_op;
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
    end
    result_s = lu_compute(sel_op_s, sel_a_s, sel_b_s);
  end

  // Next-state logic for the single response slot
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) state_next_s = RESP;
        else      state_next_s = IDLE;
      end
      RESP: begin
        if (!bus.rsp_ready) state_next_s = RESP;
        else if (hs_s)      state_next_s = RESP;
        else                state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with a registered copy of rsp_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= (state_next_s == RESP);
    end
  end

  // Response payload loads only on a handshake and otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_r   <= 1'b0;
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_zero_r <= 1'b0;
    end else if (hs_s) begin
      rsp_id_r   <= winner_s;
      rsp_data_r <= result_s;
      rsp_zero_r <= (result_s == {WIDTH{1'b0}});
    end else begin
      rsp_id_r   <= rsp_id_r;
      rsp_data_r <= rsp_data_r;
      rsp_zero_r <= rsp_zero_r;
    end
  end

  // Saturating diagnostic grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      if (grant0_s && (grant_cnt0 != 8'hFF)) grant_cnt0 <= grant_cnt0 + 8'h01;
      else                                   grant_cnt0 <= grant_cnt0;
      if (grant1_s && (grant_cnt1 != 8'hFF)) grant_cnt1 <= grant_cnt1 + 8'h01;
      else                                   grant_cnt1 <= grant_cnt1;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_zero   = rsp_zero_r;

endmodule
